// File: rtl/decode_issue_queue_pkg.sv
// pipeline_pkg: shared register-label types and the bubble constant for the decode/issue queue
package pipeline_pkg;
  localparam int REG_LABEL_W = 5;
  localparam logic [REG_LABEL_W-1:0] ZERO_REG = 5'd0;
  typedef struct packed {
    logic [REG_LABEL_W-1:0] rs1;
    logic [REG_LABEL_W-1:0] rs2;
    logic [REG_LABEL_W-1:0] rd;
    logic                   is_load;
  } labels_t;
  localparam int LABELS_W = $bits(labels_t);
  localparam labels_t BUBBLE_LABELS = '0;
endpackage

// File: rtl/decode_issue_queue_if.sv
// decode_issue_queue_if: decode-side and execute-side handshakes plus control/status of the issue queue
interface decode_issue_queue_if import pipeline_pkg::*; #(
  parameter int PAYLOAD_W = 160,
  parameter int DEPTH     = 4
);
  logic                         flush_i;
  logic                         busywait_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [PAYLOAD_W-1:0]         in_payload_i;
  logic [REG_LABEL_W-1:0]       in_rs1_i;
  logic [REG_LABEL_W-1:0]       in_rs2_i;
  logic [REG_LABEL_W-1:0]       in_rd_i;
  logic                         in_is_load_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [PAYLOAD_W-1:0]         out_payload_o;
  logic [REG_LABEL_W-1:0]       out_rs1_o;
  logic [REG_LABEL_W-1:0]       out_rs2_o;
  logic [REG_LABEL_W-1:0]       out_rd_o;
  logic                         out_is_load_o;
  logic                         load_stall_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;
  modport master (
    output flush_i, busywait_i, in_valid_i, in_payload_i, in_rs1_i, in_rs2_i, in_rd_i, in_is_load_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_payload_o, out_rs1_o, out_rs2_o, out_rd_o, out_is_load_o, load_stall_o, count_o
  );
  modport slave (
    input  flush_i, busywait_i, in_valid_i, in_payload_i, in_rs1_i, in_rs2_i, in_rd_i, in_is_load_i, out_ready_i,
    output in_ready_o, out_valid_o, out_payload_o, out_rs1_o, out_rs2_o, out_rd_o, out_is_load_o, load_stall_o, count_o
  );
endinterface

// File: rtl/decode_issue_queue_storage.sv
// circ_fifo_storage: circular buffer of decoded bundles with wrapping pointers and an occupancy count
module circ_fifo_storage #(
  parameter int W     = 176,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign rd_data_o = mem[rd_ptr];
  assign count_o   = count_q;
  // storage array carries no reset; only written entries are ever read
  always_ff @(posedge clk_i)
    if (wr_en_i) mem[wr_ptr] <= wr_data_i;
  // pointers and occupancy; flush empties the buffer
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_en_i ? wrap_inc(wr_ptr) : wr_ptr;
      rd_ptr  <= rd_en_i ? wrap_inc(rd_ptr) : rd_ptr;
      count_q <= count_q + CW'(wr_en_i & ~rd_en_i) - CW'(rd_en_i & ~wr_en_i);
    end
endmodule

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: decoded-bundle queue plus issue register with load-use bubbles, flush and empty bypass
module decode_issue_queue import pipeline_pkg::*; #(
  parameter int PAYLOAD_W = 160,
  parameter int DEPTH     = 4,
  parameter int BYPASS    = 1,
  parameter int HAZARD_EN = 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  decode_issue_queue_if.slave  bus
);
  localparam int CW      = $clog2(DEPTH+1);
  localparam int ENTRY_W = PAYLOAD_W + LABELS_W;
  labels_t              in_lab, head_lab, cand_lab, out_lab_q;
  logic [PAYLOAD_W-1:0] head_pl, cand_pl, out_pl_q;
  logic [CW-1:0]        count;
  logic                 out_valid_q, in_ready, accept, adv, head_v, cand_v, hz, take, pop, wr_en;
  assign in_lab = '{rs1: bus.in_rs1_i, rs2: bus.in_rs2_i, rd: bus.in_rd_i, is_load: bus.in_is_load_i};
  circ_fifo_storage #(.W(ENTRY_W), .DEPTH(DEPTH)) u_storage (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (bus.flush_i),
    .wr_en_i   (wr_en),
    .wr_data_i ({in_lab, bus.in_payload_i}),
    .rd_en_i   (pop),
    .rd_data_o ({head_lab, head_pl}),
    .count_o   (count)
  );
  // in_ready depends only on registered occupancy and flush, never on the execute side
  always_comb begin
    in_ready = (count < CW'(DEPTH)) & ~bus.flush_i;
    accept   = bus.in_valid_i & in_ready;
    adv      = ~bus.busywait_i & (bus.out_ready_i | ~out_valid_q);
    head_v   = count != '0;
    cand_v   = head_v | ((BYPASS != 0) & accept);
    cand_lab = head_v ? head_lab : in_lab;
    cand_pl  = head_v ? head_pl : bus.in_payload_i;
    hz       = (HAZARD_EN != 0) & out_valid_q & out_lab_q.is_load & (out_lab_q.rd != ZERO_REG) & cand_v &
               ((cand_lab.rs1 == out_lab_q.rd) | (cand_lab.rs2 == out_lab_q.rd));
    take     = adv & cand_v & ~hz & ~bus.flush_i;
    pop      = take & head_v;
    wr_en    = accept & ~(take & ~head_v);
  end
  // issue register: load the candidate on advance, otherwise a bubble; flush forces a bubble
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_lab_q   <= BUBBLE_LABELS;
      out_pl_q    <= '0;
    end else if (adv | bus.flush_i) begin
      out_valid_q <= take;
      out_lab_q   <= take ? cand_lab : BUBBLE_LABELS;
      out_pl_q    <= take ? cand_pl : '0;
    end
  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_payload_o = out_pl_q;
  assign bus.out_rs1_o     = out_lab_q.rs1;
  assign bus.out_rs2_o     = out_lab_q.rs2;
  assign bus.out_rd_o      = out_lab_q.rd;
  assign bus.out_is_load_o = out_lab_q.is_load;
  assign bus.load_stall_o  = adv & hz & ~bus.flush_i;
  assign bus.count_o       = count;
endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: directed checks of fill, bypass, load-use, x0, flush, stall, wrap and async reset
module tb_decode_issue_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  decode_issue_queue_if #(.PAYLOAD_W(32), .DEPTH(4)) a ();
  decode_issue_queue_if #(.PAYLOAD_W(32), .DEPTH(3)) b ();
  decode_issue_queue #(.PAYLOAD_W(32), .DEPTH(4), .BYPASS(0), .HAZARD_EN(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(a)
  );
  decode_issue_queue #(.PAYLOAD_W(32), .DEPTH(3), .BYPASS(1), .HAZARD_EN(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_b(input logic v, input logic [31:0] pl, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic ld);
    b.in_valid_i   = v;
    b.in_payload_i = pl;
    b.in_rs1_i     = rs1;
    b.in_rs2_i     = rs2;
    b.in_rd_i      = rd;
    b.in_is_load_i = ld;
  endtask
  initial begin
    int sent, recv;
    logic [31:0] exp_q[$];
    a.flush_i = 0; a.busywait_i = 0; a.in_valid_i = 0; a.in_payload_i = 0; a.in_rs1_i = 0;
    a.in_rs2_i = 0; a.in_rd_i = 0; a.in_is_load_i = 0; a.out_ready_i = 0;
    b.flush_i = 0; b.busywait_i = 0; b.out_ready_i = 1;
    drive_b(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_a_valid", 32'(a.out_valid_o), 0);
    chk("rst_a_count", 32'(a.count_o), 0);
    chk("rst_b_payload", b.out_payload_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_a_ready", 32'(a.in_ready_o), 1);
    tick();
    for (int i = 1; i <= 5; i++) begin
      a.in_valid_i = 1; a.in_payload_i = 32'(i);
      tick();
    end
    chk("fill_count", 32'(a.count_o), 4);
    chk("fill_issue_pl", a.out_payload_o, 1);
    chk("fill_issue_v", 32'(a.out_valid_o), 1);
    a.in_payload_i = 6;
    #1;
    chk("fill_ready_low", 32'(a.in_ready_o), 0);
    tick();
    chk("fill_count_hold", 32'(a.count_o), 4);
    a.in_valid_i = 0; a.out_ready_i = 1;
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("drain_pl", a.out_payload_o, 32'(i));
      chk("drain_count", 32'(a.count_o), 32'(5 - i));
    end
    tick();
    chk("drain_empty_v", 32'(a.out_valid_o), 0);
    drive_b(1, 32'hAB, 0, 0, 0, 0);
    tick();
    chk("byp_valid", 32'(b.out_valid_o), 1);
    chk("byp_pl", b.out_payload_o, 32'hAB);
    chk("byp_count", 32'(b.count_o), 0);
    drive_b(0, 0, 0, 0, 0, 0);
    tick();
    chk("byp_drained", 32'(b.out_valid_o), 0);
    drive_b(1, 32'h10, 0, 0, 5, 1);
    tick();
    chk("lu_load_issued", 32'(b.out_is_load_o), 1);
    drive_b(1, 32'h11, 0, 5, 0, 0);
    #1;
    chk("lu_stall", 32'(b.load_stall_o), 1);
    tick();
    chk("lu_bubble_v", 32'(b.out_valid_o), 0);
    chk("lu_bubble_ld", 32'(b.out_is_load_o), 0);
    chk("lu_queued", 32'(b.count_o), 1);
    drive_b(0, 0, 0, 0, 0, 0);
    #1;
    chk("lu_stall_once", 32'(b.load_stall_o), 0);
    tick();
    chk("lu_dep_v", 32'(b.out_valid_o), 1);
    chk("lu_dep_pl", b.out_payload_o, 32'h11);
    chk("lu_dep_rs2", 32'(b.out_rs2_o), 5);
    tick();
    drive_b(1, 32'h20, 0, 0, 0, 1);
    tick();
    drive_b(1, 32'h21, 0, 0, 0, 0);
    #1;
    chk("x0_no_stall", 32'(b.load_stall_o), 0);
    tick();
    chk("x0_issue_v", 32'(b.out_valid_o), 1);
    chk("x0_issue_pl", b.out_payload_o, 32'h21);
    drive_b(0, 0, 0, 0, 0, 0);
    tick();
    b.out_ready_i = 0;
    for (int i = 1; i <= 4; i++) begin
      drive_b(1, 32'h30 + 32'(i), 0, 0, 0, 0);
      tick();
    end
    chk("fl_pre_count", 32'(b.count_o), 3);
    chk("fl_pre_pl", b.out_payload_o, 32'h31);
    b.flush_i = 1;
    drive_b(1, 32'h35, 0, 0, 0, 0);
    #1;
    chk("fl_ready", 32'(b.in_ready_o), 0);
    tick();
    b.flush_i = 0;
    drive_b(0, 0, 0, 0, 0, 0);
    chk("fl_count", 32'(b.count_o), 0);
    chk("fl_valid", 32'(b.out_valid_o), 0);
    chk("fl_pl", b.out_payload_o, 0);
    b.out_ready_i = 1;
    tick();
    chk("fl_dropped", 32'(b.out_valid_o), 0);
    drive_b(1, 32'h41, 1, 2, 3, 0);
    tick();
    drive_b(0, 0, 0, 0, 0, 0);
    b.busywait_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bw_hold_v", 32'(b.out_valid_o), 1);
      chk("bw_hold_pl", b.out_payload_o, 32'h41);
      chk("bw_hold_rd", 32'(b.out_rd_o), 3);
    end
    b.busywait_i = 0;
    tick();
    chk("bw_release", 32'(b.out_valid_o), 0);
    drive_b(1, 32'h50, 0, 0, 7, 1);
    tick();
    b.busywait_i = 1;
    drive_b(1, 32'h51, 7, 0, 0, 0);
    #1;
    chk("bwhz_no_stall", 32'(b.load_stall_o), 0);
    tick();
    chk("bwhz_count", 32'(b.count_o), 1);
    chk("bwhz_hold_pl", b.out_payload_o, 32'h50);
    b.busywait_i = 0;
    drive_b(0, 0, 0, 0, 0, 0);
    #1;
    chk("bwhz_stall", 32'(b.load_stall_o), 1);
    tick();
    chk("bwhz_bubble", 32'(b.out_valid_o), 0);
    tick();
    chk("bwhz_dep_pl", b.out_payload_o, 32'h51);
    chk("bwhz_dep_count", 32'(b.count_o), 0);
    tick();
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 100 && recv < 10; cyc++) begin
      drive_b(sent < 10, 32'h60 + 32'(sent), 0, 0, 0, 0);
      b.out_ready_i = (cyc >= 4) && (cyc % 2 == 0);
      #1;
      if (b.in_valid_i && b.in_ready_o) begin
        exp_q.push_back(b.in_payload_i);
        sent++;
      end
      if (b.out_valid_o && b.out_ready_i) begin
        chk("wrap_order", b.out_payload_o, exp_q.pop_front());
        recv++;
      end
      tick();
    end
    chk("wrap_count", 32'(recv), 10);
    drive_b(0, 0, 0, 0, 0, 0);
    b.out_ready_i = 0;
    tick();
    drive_b(1, 32'h71, 0, 0, 0, 0);
    tick();
    drive_b(1, 32'h72, 0, 0, 0, 0);
    tick();
    drive_b(0, 0, 0, 0, 0, 0);
    chk("mr_pre_count", 32'(b.count_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_count", 32'(b.count_o), 0);
    chk("mr_valid", 32'(b.out_valid_o), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
